// File: rtl/pkt_flitizer_pkg.sv
// Shared types and helpers for the packet flitizer.
// The slot struct carries the full payload, so its widths follow the package defaults.
package pkt_flitizer_pkg;

  localparam int PKT_WIDTH     = 12144;
  localparam int PKT_FLIT_W    = 128;
  localparam int PKT_MAX_BYTES = PKT_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [PKT_WIDTH-1:0] data;
    logic [7:0]           dest;
    logic [15:0]          nflits;
  } pkt_slot_t;

  // Size is clamped before rounding up; a zero-byte packet still occupies one flit.
  function automatic logic [15:0] calc_nflits(input logic [15:0] size,
                                              input logic [15:0] max_bytes,
                                              input logic [15:0] flit_bytes);
    logic [15:0] size_c;
    logic [15:0] n;
    size_c = (size > max_bytes) ? max_bytes : size;
    n      = (size_c + flit_bytes - 16'd1) / flit_bytes;
    if (n == 16'd0) n = 16'd1;
    return n;
  endfunction

endpackage

// File: rtl/pkt_flitizer_slot_reg.sv
// One-entry packet register with load and clear; load wins over clear.
module pkt_slot_reg
  import pkt_flitizer_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load_i,
  input  logic      clr_i,
  input  pkt_slot_t slot_i,
  output pkt_slot_t slot_o
);

  pkt_slot_t slot_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else if (load_i) begin
      slot_q <= slot_i;
    end else if (clr_i) begin
      slot_q <= '0;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/pkt_flitizer.sv
// Packet-to-flit serialiser with an active and a pending packet slot.
// Optional build macro PKT_FLITIZER_STATS_EN enables the drop and sent-packet counters.
module pkt_flitizer
  import pkt_flitizer_pkg::*;
#(
  parameter int WIDTH     = PKT_WIDTH,
  parameter int FLIT_W    = PKT_FLIT_W,
  parameter int MAX_BYTES = WIDTH / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pkt_valid,
  input  logic [WIDTH-1:0]  i_pkt_data,
  input  logic [7:0]        i_pkt_dest,
  input  logic [15:0]       i_pkt_size,
  output logic              o_flit_valid,
  input  logic              i_flit_ready,
  output logic [FLIT_W-1:0] o_flit_data,
  output logic [7:0]        o_flit_dest,
  output logic              o_flit_head,
  output logic              o_flit_tail,
  output logic              o_busy,
  output logic [15:0]       o_drop_count,
  output logic [15:0]       o_pkt_count
);

  localparam int NFL_MAX = (WIDTH + FLIT_W - 1) / FLIT_W;
  localparam int PAD_W   = NFL_MAX * FLIT_W;
  localparam int SEL_W   = $clog2(NFL_MAX + 1);

  state_t      state_q, state_d;
  pkt_slot_t   act_q, pend_q, act_d, pend_d;
  pkt_slot_t   new_pkt, act_src, pend_src;
  logic        act_load, act_clr, pend_load, pend_clr;
  logic [15:0] idx_q, idx_d;
  logic        fire, tail_acc;

  logic              flit_valid_d, flit_head_d, flit_tail_d, busy_d;
  logic [FLIT_W-1:0] flit_data_d;
  logic [7:0]        flit_dest_d;
  logic              flit_valid_q, flit_head_q, flit_tail_q, busy_q;
  logic [FLIT_W-1:0] flit_data_q;
  logic [7:0]        flit_dest_q;
  logic [PAD_W-1:0]  padded;
  logic [SEL_W-1:0]  sel;

  always_comb begin
    new_pkt        = '0;
    new_pkt.valid  = 1'b1;
    new_pkt.data   = i_pkt_data;
    new_pkt.dest   = i_pkt_dest;
    new_pkt.nflits = calc_nflits(i_pkt_size, 16'(MAX_BYTES), 16'(FLIT_W / 8));
  end

  assign fire     = (state_q == SEND) && i_flit_ready;
  assign tail_acc = fire && (idx_q == act_q.nflits - 16'd1);

  pkt_slot_reg u_act (
    .clk    (clk),
    .reset  (reset),
    .load_i (act_load),
    .clr_i  (act_clr),
    .slot_i (act_src),
    .slot_o (act_q)
  );

  pkt_slot_reg u_pend (
    .clk    (clk),
    .reset  (reset),
    .load_i (pend_load),
    .clr_i  (pend_clr),
    .slot_i (pend_src),
    .slot_o (pend_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Pending promotes on tail acceptance, letting a same-cycle arrival take its place.
  always_comb begin
    act_load  = 1'b0;
    act_clr   = 1'b0;
    pend_load = 1'b0;
    pend_clr  = 1'b0;
    act_src   = new_pkt;
    pend_src  = new_pkt;
    state_d   = state_q;
    if (tail_acc && pend_q.valid) begin
      act_load = 1'b1;
      act_src  = pend_q;
      if (i_pkt_valid) pend_load = 1'b1;
      else             pend_clr  = 1'b1;
    end else if (!act_q.valid || tail_acc) begin
      if (i_pkt_valid)   act_load = 1'b1;
      else if (tail_acc) act_clr  = 1'b1;
    end else if (i_pkt_valid && !pend_q.valid) begin
      pend_load = 1'b1;
    end
    case (state_q)
      IDLE:    if (act_load) state_d = SEND;
      SEND:    if (tail_acc && !act_load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    act_d  = act_load  ? act_src  : (act_clr  ? '0 : act_q);
    pend_d = pend_load ? pend_src : (pend_clr ? '0 : pend_q);
    idx_d  = act_load ? 16'd0 : (fire ? idx_q + 16'd1 : idx_q);
  end

  // Outputs are built from next-state values so that they can be registered.
  always_comb begin
    padded       = PAD_W'(act_d.data);
    sel          = idx_d[SEL_W-1:0];
    flit_valid_d = (state_d == SEND);
    flit_data_d  = flit_valid_d ? padded[sel*FLIT_W +: FLIT_W] : '0;
    flit_dest_d  = flit_valid_d ? act_d.dest : 8'd0;
    flit_head_d  = flit_valid_d && (idx_d == 16'd0);
    flit_tail_d  = flit_valid_d && (idx_d == act_d.nflits - 16'd1);
    busy_d       = act_d.valid || pend_d.valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit_valid_q <= 1'b0;
      flit_data_q  <= '0;
      flit_dest_q  <= '0;
      flit_head_q  <= 1'b0;
      flit_tail_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      flit_valid_q <= flit_valid_d;
      flit_data_q  <= flit_data_d;
      flit_dest_q  <= flit_dest_d;
      flit_head_q  <= flit_head_d;
      flit_tail_q  <= flit_tail_d;
      busy_q       <= busy_d;
    end
  end

  assign o_flit_valid = flit_valid_q;
  assign o_flit_data  = flit_data_q;
  assign o_flit_dest  = flit_dest_q;
  assign o_flit_head  = flit_head_q;
  assign o_flit_tail  = flit_tail_q;
  assign o_busy       = busy_q;

`ifdef PKT_FLITIZER_STATS_EN
  logic        drop;
  logic [15:0] drop_cnt_q, drop_cnt_d, pkt_cnt_q, pkt_cnt_d;

  assign drop       = i_pkt_valid && pend_q.valid && !tail_acc;
  assign drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  assign pkt_cnt_d  = tail_acc ? pkt_cnt_q + 16'd1 : pkt_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign o_drop_count = drop_cnt_q;
  assign o_pkt_count  = pkt_cnt_q;
`else
  assign o_drop_count = '0;
  assign o_pkt_count  = '0;
`endif

endmodule
